// File: rtl/bios_boot_pkg.sv
// Shared definitions for the boot sequencer and the BIOS watchdog:
// state encodings, tick counter width and supply-enable polarity.
package bios_boot_pkg;

    localparam int TICK_W = 8;
    localparam logic [TICK_W-1:0] TICK_MAX = 8'd255;

    // PS_ON# is active low on the supply connector
    localparam logic PS_ON_ENABLE  = 1'b0;
    localparam logic PS_ON_DISABLE = 1'b1;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PWR_ON   = 3'd1,
        ST_BOOTING  = 3'd2,
        ST_RUNNING  = 3'd3,
        ST_SWAP_OFF = 3'd4,
        ST_FAULT    = 3'd5
    } bootState_t;

    function automatic logic supplyControl(input bootState_t st);
        logic psOnN;
        case (st)
            ST_PWR_ON, ST_BOOTING, ST_RUNNING: psOnN = PS_ON_ENABLE;
            default:                           psOnN = PS_ON_DISABLE;
        endcase
        return psOnN;
    endfunction

    function automatic logic platformHold(input bootState_t st);
        logic hold;
        case (st)
            ST_BOOTING, ST_RUNNING: hold = 1'b0;
            default:                hold = 1'b1;
        endcase
        return hold;
    endfunction

endpackage

// File: rtl/bios_boot_sequencer_if.sv
// Power/boot control bundle between the platform glue and the boot sequencer.
interface bios_boot_sequencer_if;

    logic       Strobe125msec;
    logic       PowerButton;
    logic       PowerOffReq;
    logic       PowerGood;
    logic       ForceSwap;
    logic       BiosFinished;
    logic       DefaultBiosSel;
    logic       PS_ONn;
    logic       BiosSel;
    logic       HoldReset;
    logic [1:0] RetryCnt;
    logic       BootFault;
    logic [2:0] State;

    modport master (
        output Strobe125msec, PowerButton, PowerOffReq, PowerGood,
               ForceSwap, BiosFinished, DefaultBiosSel,
        input  PS_ONn, BiosSel, HoldReset, RetryCnt, BootFault, State
    );

    modport slave (
        input  Strobe125msec, PowerButton, PowerOffReq, PowerGood,
               ForceSwap, BiosFinished, DefaultBiosSel,
        output PS_ONn, BiosSel, HoldReset, RetryCnt, BootFault, State
    );

endinterface

// File: rtl/bios_boot_sequencer_tick_timer.sv
// 8-bit saturating 125 ms tick counter with synchronous clear and limit compare.
module tick_timer
    import bios_boot_pkg::*;
(
    input  logic              LpcClock,
    input  logic              Reset,
    input  logic              clear,
    input  logic              step,
    input  logic [TICK_W-1:0] limit,
    output logic              reached
);

    logic [TICK_W-1:0] count;

    // Tick count: clear has priority over a coincident step
    always_ff @(posedge LpcClock or posedge Reset) begin
        if (Reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (step && (count != TICK_MAX)) begin
            count <= count + 8'd1;
        end else begin
            count <= count;
        end
    end

    assign reached = (count >= limit);

endmodule

// File: rtl/bios_boot_sequencer.sv
// Supply/boot sequencer: powers the board, supervises BIOS POST and power-cycles
// onto the alternate flash on watchdog swap, latching a fault after too many tries.
module bios_boot_sequencer
    import bios_boot_pkg::*;
#(
    parameter int OFF_TICKS   = 16,
    parameter int PG_TICKS    = 8,
    parameter int MAX_RETRIES = 3
) (
    input  logic                  LpcClock,
    input  logic                  Reset,
    bios_boot_sequencer_if.slave  bus
);

    localparam logic [TICK_W-1:0] OFF_LIMIT   = TICK_W'(OFF_TICKS);
    localparam logic [TICK_W-1:0] PG_LIMIT    = TICK_W'(PG_TICKS);
    localparam logic [1:0]        RETRY_LIMIT = 2'(MAX_RETRIES);

    bootState_t        state;
    bootState_t        nextState;
    logic              psOnN;
    logic              nextPsOnN;
    logic              holdRst;
    logic              nextHoldRst;
    logic              biosSel;
    logic              nextBiosSel;
    logic              bootFault;
    logic              nextBootFault;
    logic [1:0]        retryCnt;
    logic [1:0]        nextRetryCnt;
    logic              timerClear;
    logic              tickReached;
    logic [TICK_W-1:0] tickLimit;

    // Only SWAP_OFF and PWR_ON consult the timer
    assign tickLimit = (state == ST_SWAP_OFF) ? OFF_LIMIT : PG_LIMIT;

    tick_timer uTickTimer (
        .LpcClock (LpcClock),
        .Reset    (Reset),
        .clear    (timerClear),
        .step     (bus.Strobe125msec),
        .limit    (tickLimit),
        .reached  (tickReached)
    );

    // Next-state and next-output decode; event priority is encoded by if-order
    always_comb begin
        nextState     = state;
        nextBiosSel   = biosSel;
        nextRetryCnt  = retryCnt;
        nextBootFault = bootFault;
        case (state)
            ST_OFF: begin
                if (bus.PowerButton) begin
                    nextState = ST_PWR_ON;
                end else begin
                    nextState = state;
                end
            end
            ST_PWR_ON: begin
                if (bus.PowerOffReq) begin
                    nextState = ST_OFF;
                end else if (bus.PowerGood) begin
                    nextState = ST_BOOTING;
                end else if (tickReached) begin
                    nextState = ST_OFF;
                end else begin
                    nextState = state;
                end
            end
            ST_BOOTING: begin
                if (bus.PowerOffReq || !bus.PowerGood) begin
                    nextState = ST_OFF;
                end else if (bus.ForceSwap) begin
                    if (retryCnt < RETRY_LIMIT) begin
                        nextState    = ST_SWAP_OFF;
                        nextBiosSel  = ~biosSel;
                        nextRetryCnt = retryCnt + 2'd1;
                    end else begin
                        nextState     = ST_FAULT;
                        nextBootFault = 1'b1;
                    end
                end else if (bus.BiosFinished) begin
                    nextState    = ST_RUNNING;
                    nextRetryCnt = 2'd0;
                end else begin
                    nextState = state;
                end
            end
            ST_RUNNING: begin
                if (bus.PowerOffReq || !bus.PowerGood) begin
                    nextState = ST_OFF;
                end else begin
                    nextState = state;
                end
            end
            ST_SWAP_OFF: begin
                if (tickReached) begin
                    nextState = ST_PWR_ON;
                end else begin
                    nextState = state;
                end
            end
            ST_FAULT: begin
                if (bus.PowerButton) begin
                    nextState     = ST_PWR_ON;
                    nextBootFault = 1'b0;
                    nextRetryCnt  = 2'd0;
                    nextBiosSel   = bus.DefaultBiosSel;
                end else begin
                    nextState = state;
                end
            end
            default: begin
                nextState = ST_OFF;
            end
        endcase
        timerClear  = (nextState != state);
        nextPsOnN   = supplyControl(nextState);
        nextHoldRst = platformHold(nextState);
    end

    // State and output registers; reset discards any swap in progress
    always_ff @(posedge LpcClock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_OFF;
            psOnN     <= PS_ON_DISABLE;
            holdRst   <= 1'b1;
            biosSel   <= bus.DefaultBiosSel;
            retryCnt  <= 2'd0;
            bootFault <= 1'b0;
        end else begin
            state     <= nextState;
            psOnN     <= nextPsOnN;
            holdRst   <= nextHoldRst;
            biosSel   <= nextBiosSel;
            retryCnt  <= nextRetryCnt;
            bootFault <= nextBootFault;
        end
    end

    assign bus.PS_ONn    = psOnN;
    assign bus.HoldReset = holdRst;
    assign bus.BiosSel   = biosSel;
    assign bus.RetryCnt  = retryCnt;
    assign bus.BootFault = bootFault;
    assign bus.State     = state;

endmodule

// File: tb/tb_bios_boot_sequencer.sv
// Directed bench for bios_boot_sequencer: boot flow, swap/fault, PowerGood timeout,
// event priority and asynchronous reset during a swap.
module tb_bios_boot_sequencer;

    logic LpcClock;
    logic Reset;
    int   checks;
    int   errors;

    bios_boot_sequencer_if bus ();

    bios_boot_sequencer #(
        .OFF_TICKS   (16),
        .PG_TICKS    (8),
        .MAX_RETRIES (3)
    ) dut (
        .LpcClock (LpcClock),
        .Reset    (Reset),
        .bus      (bus)
    );

    initial LpcClock = 1'b0;
    always #5 LpcClock = ~LpcClock;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge LpcClock);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            bus.Strobe125msec = 1'b1;
            cyc(1);
            bus.Strobe125msec = 1'b0;
            cyc(1);
        end
    endtask

    task automatic pressButton();
        bus.PowerButton = 1'b1;
        cyc(1);
        bus.PowerButton = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Strobe125msec = 1'b0;
        bus.PowerButton = 1'b0;
        bus.PowerOffReq = 1'b0;
        bus.PowerGood = 1'b0;
        bus.ForceSwap = 1'b0;
        bus.BiosFinished = 1'b0;
        bus.DefaultBiosSel = 1'b0;
        cyc(3);
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.State, 3'd0); end
        checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL reset_ps_on: got %b expected %b", bus.PS_ONn, 1'b1); end
        checks++; if (bus.HoldReset !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b expected %b", bus.HoldReset, 1'b1); end
        checks++; if (bus.BiosSel !== 1'b0) begin errors++; $display("FAIL reset_bios_sel: got %b expected %b", bus.BiosSel, 1'b0); end
        checks++; if (bus.RetryCnt !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d expected %0d", bus.RetryCnt, 2'd0); end
        checks++; if (bus.BootFault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected %b", bus.BootFault, 1'b0); end
        Reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_boot();
        pressButton();
        checks++; if (bus.State !== 3'd1) begin errors++; $display("FAIL boot_pwr_on_state: got %0d expected %0d", bus.State, 3'd1); end
        checks++; if (bus.PS_ONn !== 1'b0) begin errors++; $display("FAIL boot_pwr_on_ps_on: got %b expected %b", bus.PS_ONn, 1'b0); end
        checks++; if (bus.HoldReset !== 1'b1) begin errors++; $display("FAIL boot_pwr_on_hold: got %b expected %b", bus.HoldReset, 1'b1); end
        tick(3);
        bus.PowerGood = 1'b1;
        cyc(1);
        checks++; if (bus.State !== 3'd2) begin errors++; $display("FAIL boot_booting_state: got %0d expected %0d", bus.State, 3'd2); end
        checks++; if (bus.HoldReset !== 1'b0) begin errors++; $display("FAIL boot_booting_hold: got %b expected %b", bus.HoldReset, 1'b0); end
        bus.BiosFinished = 1'b1;
        cyc(1);
        bus.BiosFinished = 1'b0;
        checks++; if (bus.State !== 3'd3) begin errors++; $display("FAIL boot_running_state: got %0d expected %0d", bus.State, 3'd3); end
        checks++; if (bus.RetryCnt !== 2'd0) begin errors++; $display("FAIL boot_running_retry: got %0d expected %0d", bus.RetryCnt, 2'd0); end
        bus.ForceSwap = 1'b1;
        cyc(1);
        bus.ForceSwap = 1'b0;
        checks++; if (bus.State !== 3'd3) begin errors++; $display("FAIL running_ignores_swap: got %0d expected %0d", bus.State, 3'd3); end
        checks++; if (bus.BiosSel !== 1'b0) begin errors++; $display("FAIL running_swap_sel: got %b expected %b", bus.BiosSel, 1'b0); end
        bus.PowerGood = 1'b0;
        cyc(1);
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL running_pg_loss: got %0d expected %0d", bus.State, 3'd0); end
        checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL running_pg_loss_ps_on: got %b expected %b", bus.PS_ONn, 1'b1); end
    endtask

    task automatic test_swap_fault();
        logic       expSel;
        logic [1:0] expRetry;
        bus.PowerGood = 1'b1;
        pressButton();
        cyc(1);
        checks++; if (bus.State !== 3'd2) begin errors++; $display("FAIL swap_start_booting: got %0d expected %0d", bus.State, 3'd2); end
        for (int i = 1; i <= 3; i++) begin
            expSel   = (i % 2 == 1) ? 1'b1 : 1'b0;
            expRetry = 2'(i);
            bus.ForceSwap = 1'b1;
            cyc(1);
            bus.ForceSwap = 1'b0;
            checks++; if (bus.State !== 3'd4) begin errors++; $display("FAIL swap%0d_state: got %0d expected %0d", i, bus.State, 3'd4); end
            checks++; if (bus.BiosSel !== expSel) begin errors++; $display("FAIL swap%0d_sel: got %b expected %b", i, bus.BiosSel, expSel); end
            checks++; if (bus.RetryCnt !== expRetry) begin errors++; $display("FAIL swap%0d_retry: got %0d expected %0d", i, bus.RetryCnt, expRetry); end
            checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL swap%0d_ps_on: got %b expected %b", i, bus.PS_ONn, 1'b1); end
            bus.PowerGood = 1'b0;
            tick(15);
            checks++; if (bus.State !== 3'd4) begin errors++; $display("FAIL swap%0d_hold15: got %0d expected %0d", i, bus.State, 3'd4); end
            checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL swap%0d_hold15_ps_on: got %b expected %b", i, bus.PS_ONn, 1'b1); end
            tick(1);
            checks++; if (bus.State !== 3'd1) begin errors++; $display("FAIL swap%0d_repower: got %0d expected %0d", i, bus.State, 3'd1); end
            checks++; if (bus.PS_ONn !== 1'b0) begin errors++; $display("FAIL swap%0d_repower_ps_on: got %b expected %b", i, bus.PS_ONn, 1'b0); end
            checks++; if (bus.BiosSel !== expSel) begin errors++; $display("FAIL swap%0d_repower_sel: got %b expected %b", i, bus.BiosSel, expSel); end
            bus.PowerGood = 1'b1;
            cyc(1);
            checks++; if (bus.State !== 3'd2) begin errors++; $display("FAIL swap%0d_reboot: got %0d expected %0d", i, bus.State, 3'd2); end
        end
        bus.ForceSwap = 1'b1;
        cyc(1);
        bus.ForceSwap = 1'b0;
        checks++; if (bus.State !== 3'd5) begin errors++; $display("FAIL fault_state: got %0d expected %0d", bus.State, 3'd5); end
        checks++; if (bus.BootFault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b expected %b", bus.BootFault, 1'b1); end
        checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL fault_ps_on: got %b expected %b", bus.PS_ONn, 1'b1); end
        checks++; if (bus.BiosSel !== 1'b1) begin errors++; $display("FAIL fault_sel: got %b expected %b", bus.BiosSel, 1'b1); end
        checks++; if (bus.RetryCnt !== 2'd3) begin errors++; $display("FAIL fault_retry: got %0d expected %0d", bus.RetryCnt, 2'd3); end
        cyc(4);
        checks++; if (bus.State !== 3'd5) begin errors++; $display("FAIL fault_latched: got %0d expected %0d", bus.State, 3'd5); end
        pressButton();
        checks++; if (bus.State !== 3'd1) begin errors++; $display("FAIL fault_exit_state: got %0d expected %0d", bus.State, 3'd1); end
        checks++; if (bus.BootFault !== 1'b0) begin errors++; $display("FAIL fault_exit_flag: got %b expected %b", bus.BootFault, 1'b0); end
        checks++; if (bus.RetryCnt !== 2'd0) begin errors++; $display("FAIL fault_exit_retry: got %0d expected %0d", bus.RetryCnt, 2'd0); end
        checks++; if (bus.BiosSel !== 1'b0) begin errors++; $display("FAIL fault_exit_sel: got %b expected %b", bus.BiosSel, 1'b0); end
        bus.PowerOffReq = 1'b1;
        cyc(1);
        bus.PowerOffReq = 1'b0;
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL pwr_on_off_req: got %0d expected %0d", bus.State, 3'd0); end
    endtask

    task automatic test_pg_timeout();
        bus.PowerGood = 1'b1;
        pressButton();
        cyc(1);
        bus.ForceSwap = 1'b1;
        cyc(1);
        bus.ForceSwap = 1'b0;
        bus.PowerGood = 1'b0;
        tick(16);
        checks++; if (bus.State !== 3'd1) begin errors++; $display("FAIL pg_to_pwr_on: got %0d expected %0d", bus.State, 3'd1); end
        tick(7);
        checks++; if (bus.State !== 3'd1) begin errors++; $display("FAIL pg_to_wait7: got %0d expected %0d", bus.State, 3'd1); end
        tick(1);
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL pg_to_off: got %0d expected %0d", bus.State, 3'd0); end
        checks++; if (bus.BiosSel !== 1'b1) begin errors++; $display("FAIL pg_to_sel: got %b expected %b", bus.BiosSel, 1'b1); end
        checks++; if (bus.RetryCnt !== 2'd1) begin errors++; $display("FAIL pg_to_retry: got %0d expected %0d", bus.RetryCnt, 2'd1); end
        checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL pg_to_ps_on: got %b expected %b", bus.PS_ONn, 1'b1); end
    endtask

    task automatic test_priority();
        bus.PowerGood = 1'b1;
        pressButton();
        cyc(1);
        bus.ForceSwap = 1'b1;
        bus.PowerOffReq = 1'b1;
        cyc(1);
        bus.ForceSwap = 1'b0;
        bus.PowerOffReq = 1'b0;
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL prio_off_state: got %0d expected %0d", bus.State, 3'd0); end
        checks++; if (bus.BiosSel !== 1'b1) begin errors++; $display("FAIL prio_off_sel: got %b expected %b", bus.BiosSel, 1'b1); end
        checks++; if (bus.RetryCnt !== 2'd1) begin errors++; $display("FAIL prio_off_retry: got %0d expected %0d", bus.RetryCnt, 2'd1); end
        pressButton();
        cyc(1);
        bus.ForceSwap = 1'b1;
        bus.BiosFinished = 1'b1;
        cyc(1);
        bus.ForceSwap = 1'b0;
        bus.BiosFinished = 1'b0;
        bus.PowerGood = 1'b0;
        checks++; if (bus.State !== 3'd4) begin errors++; $display("FAIL prio_swap_state: got %0d expected %0d", bus.State, 3'd4); end
        checks++; if (bus.BiosSel !== 1'b0) begin errors++; $display("FAIL prio_swap_sel: got %b expected %b", bus.BiosSel, 1'b0); end
        checks++; if (bus.RetryCnt !== 2'd2) begin errors++; $display("FAIL prio_swap_retry: got %0d expected %0d", bus.RetryCnt, 2'd2); end
    endtask

    task automatic test_reset_mid_swap();
        tick(5);
        checks++; if (bus.State !== 3'd4) begin errors++; $display("FAIL midswap_before: got %0d expected %0d", bus.State, 3'd4); end
        bus.DefaultBiosSel = 1'b1;
        Reset = 1'b1;
        #1;
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL midswap_state: got %0d expected %0d", bus.State, 3'd0); end
        checks++; if (bus.PS_ONn !== 1'b1) begin errors++; $display("FAIL midswap_ps_on: got %b expected %b", bus.PS_ONn, 1'b1); end
        checks++; if (bus.HoldReset !== 1'b1) begin errors++; $display("FAIL midswap_hold: got %b expected %b", bus.HoldReset, 1'b1); end
        checks++; if (bus.BiosSel !== 1'b1) begin errors++; $display("FAIL midswap_sel: got %b expected %b", bus.BiosSel, 1'b1); end
        checks++; if (bus.RetryCnt !== 2'd0) begin errors++; $display("FAIL midswap_retry: got %0d expected %0d", bus.RetryCnt, 2'd0); end
        checks++; if (bus.BootFault !== 1'b0) begin errors++; $display("FAIL midswap_fault: got %b expected %b", bus.BootFault, 1'b0); end
        cyc(2);
        Reset = 1'b0;
        tick(20);
        checks++; if (bus.State !== 3'd0) begin errors++; $display("FAIL post_reset_idle: got %0d expected %0d", bus.State, 3'd0); end
        checks++; if (bus.BiosSel !== 1'b1) begin errors++; $display("FAIL post_reset_sel: got %b expected %b", bus.BiosSel, 1'b1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_boot();
        test_swap_fault();
        test_pg_timeout();
        test_priority();
        test_reset_mid_swap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
